ex_mem_fwd_stage: RTL and testbench
===================================

# ex_mem_fwd_stage

Parametrised EX→MEM pipeline stage register for the RISC-V core, between the execute stage and the memory stage. It carries a valid/ready handshake, stall and flush, and priority-encoded store-data forwarding from NUM_FWD downstream write-back sources. When enabled, it also keeps refreshing a stalled store's data until that store leaves the stage.

## Interface
- XLEN, 32: datapath width (pc, instruction fixed at 32).
- NUM_FWD, 2: downstream forwarding sources; index 0 = nearest (MEM), highest priority.
- CNT_W, 16: width of forward-event counter.

- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- flush  in  1  kill stage contents and any same-cycle incoming transfer.
- in_valid  in  1  EX has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  32  pc.
- in_insn  in  32  instruction.
- in_alu_res  in  XLEN  EX result / store address.
- in_rs2  in  XLEN  rs2 value read in EX.
- out_valid  out  1  stage holds a live instruction.
- out_ready  in  1  MEM consumes this cycle.
- out_pc, out_insn  out  32  registered pc and instruction.
- out_alu_res, out_rs2  out  XLEN  registered result and store data.
- src_valid  in  NUM_FWD  source i holds a live instruction.
- src_insn  in  NUM_FWD*32  source instructions, flattened, source i at [32i+31:32i].
- src_alu_res, src_mem_res  in  NUM_FWD*XLEN  source ALU and load results.
- fwd_count  out  CNT_W  count of forwarding substitutions.

## Operation
- Producers: a source produces its rd when all of the following hold: src_valid, rd≠0, and opcode ∈ {LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011}.
- Source value: src_mem_res when the source opcode is LOAD; src_alu_res otherwise.
- Consumers: a consumer is a store (opcode 0100011) whose rs2 = insn[24:20].
- Forwarding: the lowest-index producing source whose rd equals the consumer's rs2 supplies the store data. If no source matches, the store data is in_rs2 (at capture) or unchanged (while held).
- Forwarding scope: non-store instructions never forward; out_rs2 takes in_rs2 verbatim.
- Capture: on in_valid && in_ready, the stage loads pc, insn, alu_res, and forwarded rs2, and sets out_valid.
- in_ready = !out_valid || out_ready || flush.
- Consume without new transfer: out_valid && out_ready && !capture clears out_valid.
- Stall: out_valid && !out_ready holds all outputs, except the snoop update (see Configuration).
- Flush: flush has priority over capture. out_valid is cleared next cycle, and the incoming transfer is accepted and dropped; data registers may retain stale values.
- Counter: fwd_count increments by 1 on each cycle in which a forwarding substitution is written into out_rs2, whether at capture or by snoop. It wraps at 2^CNT_W, and reset clears it.

## Timing
- Latency: 1 cycle from capture edge to outputs; all outputs are registered.
- Combinational paths: in_ready is combinational from out_valid, out_ready, and flush. No other combinational path runs input→output.
- Reset: out_valid=0, out_pc=0, out_insn=0, out_alu_res=0, out_rs2=0, fwd_count=0. in_ready reads 1 during reset.
- Reset mid-stall: the held instruction is discarded.
- Simultaneous consume+capture: the new instruction replaces the old one and out_valid stays 1.
- Simultaneous flush+reset: reset dominates, with the same result.
- Multiple matching sources: index 0 wins, and the counter counts 1.

## Configuration
- EX_MEM_FWD_SNOOP_EN defined: while out_valid && !out_ready && !flush and the held instruction is a store, the forwarding match against the held out_insn is re-evaluated each cycle. A match overwrites out_rs2.
- EX_MEM_FWD_SNOOP_EN undefined: forwarding happens only at capture, and held data never changes.

## Structure
- Package rv_pipe_pkg holds:
  - opcode localparams;
  - function writes_rd(opcode);
  - field-extract functions rd_of/rs2_of/opcode_of.
- Sub-module fwd_select (parameters NUM_FWD, XLEN) is a combinational priority matcher with:
  - inputs: consumer instruction, default data, and the source buses;
  - outputs: hit and data.
- The stage instantiates fwd_select twice: once on in_insn for capture, and once on out_insn for snoop (present only under the macro).

## Test plan
- Plain capture: ADDI insn 0x00500093, pc=0x100, alu=5, rs2=7, no sources → next cycle out_valid=1, out_alu_res=5, out_rs2=7, fwd_count=0.
- Load forwarding: store rs2=x2 (insn 0x00202023), src0 = LOAD rd=x2, mem_res=0xDEADBEEF, alu_res=0x40 → out_rs2=0xDEADBEEF, fwd_count=1.
- Priority and x0:
  - src0 = ADD rd=x2 with alu 0x11, and src1 = ADD rd=x2 with alu 0x22 → out_rs2=0x11.
  - Store rs2=x0 with src0 rd=x0 → out_rs2=in_rs2, no count.
- Stall then snoop: hold a store with out_ready=0 for 3 cycles, and drive src0 with rd=rs2 and alu=0x99 in cycle 2:
  - with EX_MEM_FWD_SNOOP_EN: out_rs2=0x99 from cycle 3 and count+1;
  - without it: unchanged.
- Flush and handshake:
  - flush with in_valid=1 → next cycle out_valid=0 and in_ready=1.
  - out_valid=1, out_ready=1, in_valid=1 → the new instruction appears and out_valid stays 1.
- Reset mid-stall: reset asserted with out_valid=1 → all outputs zero next cycle, and fwd_count=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline definitions: major opcodes and instruction field helpers.
// Ports: none (package only).
// Imported by the EX/MEM stage register and its forwarding matcher.
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    function automatic logic [6:0] opcode_of(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] insn);
        return insn[11:7];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] insn);
        return insn[24:20];
    endfunction

    // Opcodes whose rd field names a real architectural destination.
    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_fwd_stage_fwd_select.sv
// Combinational store-data forwarding matcher over NUM_FWD write-back sources.
// Ports: cons_insn_i/dflt_dat_i (consumer and fallback data), src_* buses in,
//        hit_o/dat_o out; source 0 is nearest and wins over higher indices.
module fwd_select
    import rv_pipe_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int XLEN    = 32
) (
    input  logic [31:0]           cons_insn_i,
    input  logic [XLEN-1:0]       dflt_dat_i,
    input  logic [NUM_FWD-1:0]    src_valid_i,
    input  logic [NUM_FWD*32-1:0] src_insn_i,
    input  logic [NUM_FWD*XLEN-1:0] src_alu_res_i,
    input  logic [NUM_FWD*XLEN-1:0] src_mem_res_i,
    output logic                  hit_o,
    output logic [XLEN-1:0]       dat_o
);

    always_comb begin
        hit_o = 1'b0;
        dat_o = dflt_dat_i;
        if (opcode_of(cons_insn_i) == OPC_STORE) begin
            // Walk from the farthest source down so the nearest match is applied last.
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (src_valid_i[i]
                    && writes_rd(opcode_of(src_insn_i[32*i +: 32]))
                    && (rd_of(src_insn_i[32*i +: 32]) != 5'd0)
                    && (rd_of(src_insn_i[32*i +: 32]) == rs2_of(cons_insn_i))) begin
                    hit_o = 1'b1;
                    dat_o = (opcode_of(src_insn_i[32*i +: 32]) == OPC_LOAD)
                          ? src_mem_res_i[XLEN*i +: XLEN]
                          : src_alu_res_i[XLEN*i +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/ex_mem_fwd_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and store-data forwarding.
// Ports: clock/reset (sync, active-high), flush, in_* from EX, out_* to MEM,
//        src_* forwarding sources, fwd_count substitution counter.
// Option: define EX_MEM_FWD_SNOOP_EN to keep refreshing a stalled store's data.
module ex_mem_fwd_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_insn,
    input  logic [XLEN-1:0]         in_alu_res,
    input  logic [XLEN-1:0]         in_rs2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_insn,
    output logic [XLEN-1:0]         out_alu_res,
    output logic [XLEN-1:0]         out_rs2,
    input  logic [NUM_FWD-1:0]      src_valid,
    input  logic [NUM_FWD*32-1:0]   src_insn,
    input  logic [NUM_FWD*XLEN-1:0] src_alu_res,
    input  logic [NUM_FWD*XLEN-1:0] src_mem_res,
    output logic [CNT_W-1:0]        fwd_count
);

    logic            valid_q, valid_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     insn_q, insn_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            capture;
    logic            cap_hit;
    logic [XLEN-1:0] cap_dat;

    // Reset term keeps in_ready high even before the valid flop has settled.
    assign in_ready = reset || !valid_q || out_ready || flush;
    assign capture  = in_valid && in_ready && !flush;

    fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_cap_fwd (
        .cons_insn_i   (in_insn),
        .dflt_dat_i    (in_rs2),
        .src_valid_i   (src_valid),
        .src_insn_i    (src_insn),
        .src_alu_res_i (src_alu_res),
        .src_mem_res_i (src_mem_res),
        .hit_o         (cap_hit),
        .dat_o         (cap_dat)
    );

`ifdef EX_MEM_FWD_SNOOP_EN
    logic            snp_hit;
    logic [XLEN-1:0] snp_dat;

    fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_snp_fwd (
        .cons_insn_i   (insn_q),
        .dflt_dat_i    (rs2_q),
        .src_valid_i   (src_valid),
        .src_insn_i    (src_insn),
        .src_alu_res_i (src_alu_res),
        .src_mem_res_i (src_mem_res),
        .hit_o         (snp_hit),
        .dat_o         (snp_dat)
    );
`endif

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        alu_d   = alu_q;
        rs2_d   = rs2_q;
        cnt_d   = cnt_q;
        if (flush) begin
            // Incoming transfer is accepted and dropped; data regs keep stale values.
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            insn_d  = in_insn;
            alu_d   = in_alu_res;
            rs2_d   = cap_dat;
            if (cap_hit) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
`ifdef EX_MEM_FWD_SNOOP_EN
        end else if (valid_q && snp_hit) begin
            // Reaching here implies a stall without flush.
            rs2_d = snp_dat;
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            insn_q  <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            alu_q   <= alu_d;
            rs2_q   <= rs2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_insn    = insn_q;
    assign out_alu_res = alu_q;
    assign out_rs2     = rs2_q;
    assign fwd_count   = cnt_q;

endmodule

// File: tb/tb_ex_mem_fwd_stage.sv
// Bench for ex_mem_fwd_stage: directed scenarios plus a randomized run against a reference model.
module tb_ex_mem_fwd_stage;

`ifdef EX_MEM_FWD_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_pc, in_insn, in_alu_res, in_rs2;
    logic [31:0] out_pc, out_insn, out_alu_res, out_rs2;
    logic [1:0]  src_valid;
    logic [63:0] src_insn, src_alu_res, src_mem_res;
    logic [15:0] fwd_count;

    logic [31:0] s_insn [2];
    logic [31:0] s_alu  [2];
    logic [31:0] s_mem  [2];

    assign src_insn    = {s_insn[1], s_insn[0]};
    assign src_alu_res = {s_alu[1],  s_alu[0]};
    assign src_mem_res = {s_mem[1],  s_mem[0]};

    int checks = 0;
    int errors = 0;

    // Reference state
    logic        m_valid;
    logic [31:0] m_pc, m_insn, m_alu, m_rs2;
    logic [15:0] m_cnt;

    always #5 clock = ~clock;

    ex_mem_fwd_stage #(.XLEN(32), .NUM_FWD(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_alu_res(out_alu_res), .out_rs2(out_rs2),
        .src_valid(src_valid), .src_insn(src_insn),
        .src_alu_res(src_alu_res), .src_mem_res(src_mem_res),
        .fwd_count(fwd_count)
    );

    // Store data a store would see from the current sources; nearest producer wins.
    function automatic logic [31:0] ref_fwd(input logic [31:0] insn, input logic [31:0] dflt,
                                            output bit hit);
        logic [6:0] op;
        logic [4:0] rd;
        hit = 1'b0;
        if (insn[6:0] != 7'b0100011) return dflt;
        for (int i = 0; i < 2; i++) begin
            op = s_insn[i][6:0];
            rd = s_insn[i][11:7];
            if (src_valid[i] && rd != 5'd0 && rd == insn[24:20] &&
                op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b0000011, 7'b0010011, 7'b0110011}) begin
                hit = 1'b1;
                return (op == 7'b0000011) ? s_mem[i] : s_alu[i];
            end
        end
        return dflt;
    endfunction

    function automatic logic model_in_ready();
        return reset || !m_valid || out_ready || flush;
    endfunction

    task automatic model_step();
        bit h;
        logic [31:0] d;
        if (reset) begin
            m_valid = 0; m_pc = 0; m_insn = 0; m_alu = 0; m_rs2 = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && model_in_ready()) begin
            d = ref_fwd(in_insn, in_rs2, h);
            m_valid = 1; m_pc = in_pc; m_insn = in_insn; m_alu = in_alu_res; m_rs2 = d;
            if (h) m_cnt = m_cnt + 16'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else if (SNOOP && m_valid) begin
            d = ref_fwd(m_insn, m_rs2, h);
            if (h) begin
                m_rs2 = d;
                m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_srcs();
        src_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s_insn[i] = 32'h0; s_alu[i] = 32'h0; s_mem[i] = 32'h0;
        end
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_pc = 0; in_insn = 0; in_alu_res = 0; in_rs2 = 0;
        clear_srcs();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        cycle();
        cycle();
        checks++;
        if ({out_valid, out_pc, out_insn, out_alu_res, out_rs2, fwd_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b pc=%h insn=%h alu=%h rs2=%h cnt=%h exp all 0",
                     out_valid, out_pc, out_insn, out_alu_res, out_rs2, fwd_count);
        end
        reset = 0;
    endtask

    task automatic test_plain_capture();
        in_valid = 1; in_pc = 32'h100; in_insn = 32'h00500093; in_alu_res = 5; in_rs2 = 7;
        out_ready = 0;
        cycle();
        in_valid = 0;
        checks++;
        if ({out_valid, out_pc, out_alu_res, out_rs2, fwd_count} !== {1'b1, 32'h100, 32'd5, 32'd7, 16'd0}) begin
            errors++;
            $display("FAIL plain_capture got v=%b pc=%h alu=%h rs2=%h cnt=%0d exp v=1 pc=100 alu=5 rs2=7 cnt=0",
                     out_valid, out_pc, out_alu_res, out_rs2, fwd_count);
        end
        out_ready = 1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL consume_clears got %b exp 0", out_valid); end
    endtask

    task automatic test_load_fwd();
        in_valid = 1; in_pc = 32'h104; in_insn = 32'h00202023; in_alu_res = 32'h40; in_rs2 = 32'h1234;
        src_valid = 2'b01; s_insn[0] = 32'h00002103; s_alu[0] = 32'h40; s_mem[0] = 32'hDEADBEEF;
        cycle();
        in_valid = 0; clear_srcs();
        checks++;
        if (out_rs2 !== 32'hDEADBEEF || fwd_count !== 16'd1) begin
            errors++;
            $display("FAIL load_fwd got rs2=%h cnt=%0d exp rs2=deadbeef cnt=1", out_rs2, fwd_count);
        end
        cycle();
    endtask

    task automatic test_priority_x0();
        in_valid = 1; in_pc = 32'h108; in_insn = 32'h00202023; in_rs2 = 32'h5555;
        src_valid = 2'b11;
        s_insn[0] = 32'h00000133; s_alu[0] = 32'h11;
        s_insn[1] = 32'h00000133; s_alu[1] = 32'h22;
        cycle();
        checks++;
        if (out_rs2 !== 32'h11 || fwd_count !== 16'd2) begin
            errors++;
            $display("FAIL priority got rs2=%h cnt=%0d exp rs2=11 cnt=2", out_rs2, fwd_count);
        end
        clear_srcs();
        in_insn = 32'h00002023; in_rs2 = 32'hABCD;
        src_valid = 2'b01; s_insn[0] = 32'h00500013; s_alu[0] = 32'h55;
        cycle();
        in_valid = 0; clear_srcs();
        checks++;
        if (out_rs2 !== 32'hABCD || fwd_count !== 16'd2) begin
            errors++;
            $display("FAIL x0_no_fwd got rs2=%h cnt=%0d exp rs2=abcd cnt=2", out_rs2, fwd_count);
        end
        // A non-store matching a producer must not forward
        in_valid = 1; in_insn = 32'h00200093; in_rs2 = 32'h3333;
        src_valid = 2'b01; s_insn[0] = 32'h00000133; s_alu[0] = 32'h44;
        cycle();
        in_valid = 0; clear_srcs();
        checks++;
        if (out_rs2 !== 32'h3333 || fwd_count !== 16'd2) begin
            errors++;
            $display("FAIL nonstore_no_fwd got rs2=%h cnt=%0d exp rs2=3333 cnt=2", out_rs2, fwd_count);
        end
        cycle();
    endtask

    task automatic test_stall_snoop();
        logic [31:0] exp_rs2;
        logic [15:0] exp_cnt;
        in_valid = 1; in_pc = 32'h200; in_insn = 32'h00202023; in_rs2 = 32'h77; out_ready = 1;
        cycle();
        in_valid = 0; out_ready = 0;
        cycle();
        checks++;
        if (out_rs2 !== 32'h77 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold got v=%b rs2=%h exp v=1 rs2=77", out_valid, out_rs2);
        end
        src_valid = 2'b01; s_insn[0] = 32'h00000133; s_alu[0] = 32'h99;
        cycle();
        clear_srcs();
        exp_rs2 = SNOOP ? 32'h99 : 32'h77;
        exp_cnt = SNOOP ? 16'd3 : 16'd2;
        checks++;
        if (out_rs2 !== exp_rs2 || fwd_count !== exp_cnt) begin
            errors++;
            $display("FAIL snoop got rs2=%h cnt=%0d exp rs2=%h cnt=%0d", out_rs2, fwd_count, exp_rs2, exp_cnt);
        end
        cycle();
        checks++;
        if (out_rs2 !== exp_rs2 || out_valid !== 1'b1 || fwd_count !== exp_cnt) begin
            errors++;
            $display("FAIL snoop_hold got v=%b rs2=%h cnt=%0d exp v=1 rs2=%h cnt=%0d",
                     out_valid, out_rs2, fwd_count, exp_rs2, exp_cnt);
        end
        out_ready = 1;
        cycle();
    endtask

    task automatic test_flush();
        in_valid = 1; in_pc = 32'h300; in_insn = 32'h00500093; out_ready = 0;
        cycle();
        flush = 1; in_pc = 32'h304;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        cycle();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; in_pc = 32'h400; in_insn = 32'h00100093;
        cycle();
        in_pc = 32'h404; in_insn = 32'h00200113; in_alu_res = 32'hBEEF;
        cycle();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h404 || out_insn !== 32'h00200113 || out_alu_res !== 32'hBEEF) begin
            errors++;
            $display("FAIL back_to_back got v=%b pc=%h insn=%h alu=%h exp v=1 pc=404 insn=00200113 alu=beef",
                     out_valid, out_pc, out_insn, out_alu_res);
        end
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1; in_pc = 32'h500; in_insn = 32'h00202023; in_rs2 = 32'h9;
        src_valid = 2'b01; s_insn[0] = 32'h00000133; s_alu[0] = 32'h66; out_ready = 1;
        cycle();
        in_valid = 0; out_ready = 0; clear_srcs();
        cycle();
        reset = 1; flush = 1;
        cycle();
        reset = 0; flush = 0;
        checks++;
        if ({out_valid, out_pc, out_insn, out_alu_res, out_rs2, fwd_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall got v=%b pc=%h insn=%h alu=%h rs2=%h cnt=%h exp all 0",
                     out_valid, out_pc, out_insn, out_alu_res, out_rs2, fwd_count);
        end
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                                 7'b0010011, 7'b0110011, 7'b0100011, 7'b1100011, 7'b1110011};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_pc      = $urandom;
            in_alu_res = $urandom;
            in_rs2     = $urandom;
            in_insn    = ($urandom_range(0, 1) != 0) ? {rand_insn()} : {rand_insn()[31:7], 7'b0100011};
            src_valid  = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                s_insn[i] = rand_insn(); s_alu[i] = $urandom; s_mem[i] = $urandom;
            end
            #1;
            checks++;
            if (in_ready !== model_in_ready()) begin
                errors++; $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, in_ready, model_in_ready());
            end
            cycle();
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, m_valid);
            end
            checks++;
            if (m_valid && {out_pc, out_insn, out_alu_res} !== {m_pc, m_insn, m_alu}) begin
                errors++;
                $display("FAIL rnd_data n=%0d got pc=%h insn=%h alu=%h exp pc=%h insn=%h alu=%h",
                         n, out_pc, out_insn, out_alu_res, m_pc, m_insn, m_alu);
            end
            checks++;
            if (m_valid && out_rs2 !== m_rs2) begin
                errors++; $display("FAIL rnd_rs2 n=%0d got %h exp %h", n, out_rs2, m_rs2);
            end
            checks++;
            if (fwd_count !== m_cnt) begin
                errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, fwd_count, m_cnt);
            end
        end
        in_valid = 0; flush = 0; clear_srcs();
    endtask

    initial begin
        test_reset();
        test_plain_capture();
        test_load_fwd();
        test_priority_x0();
        test_stall_snoop();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
